// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache: combinational hits, 128-bit block refill on a miss.
// Defining ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache_fetch #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [31:0]                    PC,
    output logic [31:0]                    INSTRUCTION,
    output logic                           BUSYWAIT,
    output logic                           mem_read,
    output logic [TAG_BITS+INDEX_BITS-1:0] mem_address,
    input  logic [127:0]                   mem_readdata,
    input  logic                           mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]                    hit_count,
    output logic [15:0]                    miss_count
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int BLK_BITS = TAG_BITS + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    state_t                state;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [127:0]          data_mem [LINES];

    logic [1:0]            pc_offset;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [127:0]          line_data;
    logic                  hit;
    logic                  unused_pc_bits;

    assign pc_offset      = PC[3:2];
    assign pc_index       = PC[INDEX_BITS+3:4];
    assign pc_tag         = PC[BLK_BITS+3:INDEX_BITS+4];
    assign unused_pc_bits = ^{PC[31:BLK_BITS+4], PC[1:0]};

    // The latched block address doubles as the refill target, so the refill never looks at PC.
    assign fill_index = mem_address[INDEX_BITS-1:0];
    assign fill_tag   = mem_address[BLK_BITS-1:INDEX_BITS];

    assign line_data   = data_mem[pc_index];
    assign hit         = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
    assign BUSYWAIT    = !RESET && ((state != IDLE) || !hit);
    assign INSTRUCTION = (!RESET && hit) ? line_data[{pc_offset, 5'b0} +: 32] : 32'd0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_address <= '0;
            valid       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        mem_address <= {pc_tag, pc_index};
                        mem_read    <= 1'b1;
                        state       <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        mem_read <= 1'b0;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid[fill_index] <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset: a line is only ever read once its valid bit is set.
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            data_mem[fill_index] <= mem_readdata;
            tag_mem[fill_index]  <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] pc_prev;

    // A hit only counts when the cpu held the same PC across the whole cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_prev    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            pc_prev <= PC;
            if ((state == IDLE) && hit && (PC == pc_prev) && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
            if ((state == IDLE) && !hit && (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios with literal expectations plus
// randomized fetches checked every cycle against a transaction-level cache model.
module tb_icache_fetch;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    icache_fetch dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory contents: word w of block b is easy to recognise by eye.
    function automatic logic [31:0] mem_word(input int b, input int w);
        return 32'hC0DE_0000 | (32'(b) << 8) | 32'(w);
    endfunction

    function automatic logic [127:0] mem_block(input logic [5:0] b);
        logic [127:0] r;
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = mem_word(int'(b), w);
        return r;
    endfunction

    // Instruction memory: busy for lat_cur-1 sampled edges, garbage on the bus while busy.
    int           cnt      = 0;
    int           lat_cur  = 5;
    int           lat_next = 5;
    logic         noise    = 1'b0;
    logic [127:0] garbage  = '0;
    logic [5:0]   req_addr = '0;

    always @(posedge CLK) begin
        if (mem_read) begin
            cnt      <= cnt + 1;
            req_addr <= mem_address;
        end else begin
            cnt     <= 0;
            lat_cur <= lat_next;
        end
        garbage <= {$urandom, $urandom, $urandom, $urandom};
    end

    assign mem_busywait = mem_read ? (cnt < lat_cur - 1) : noise;
    assign mem_readdata = (mem_read && mem_busywait) ? garbage
                                                     : mem_block(mem_read ? mem_address : req_addr);

    // Reference model: which block each line holds, plus one outstanding refill transaction.
    bit          m_valid [8];
    int          m_tag   [8];
    bit          m_refill  = 1'b0;
    bit          m_arrived = 1'b0;
    int          m_blk     = 0;
    logic [31:0] m_prev_pc = '0;
    int          m_hits    = 0;
    int          m_misses  = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 16) % 8);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc / 128) % 8);
    endfunction

    function automatic int off_of(input logic [31:0] pc);
        return int'((pc / 4) % 4);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_refill  = 1'b0;
            m_arrived = 1'b0;
            m_prev_pc = '0;
            m_hits    = 0;
            m_misses  = 0;
        end else begin
            if (!m_refill) begin
                if (!m_hit(PC)) begin
                    m_refill  = 1'b1;
                    m_arrived = 1'b0;
                    m_blk     = tag_of(PC) * 8 + idx_of(PC);
                    if (m_misses < 65535) m_misses++;
                end else if (PC == m_prev_pc && m_hits < 65535) begin
                    m_hits++;
                end
            end else if (!m_arrived) begin
                if (!mem_busywait) m_arrived = 1'b1;
            end else begin
                m_valid[m_blk % 8] = 1'b1;
                m_tag[m_blk % 8]   = m_blk / 8;
                m_refill           = 1'b0;
            end
            m_prev_pc = PC;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin : compare_proc
        logic        exp_bw;
        logic        exp_rd;
        logic [31:0] exp_ins;
        if (chk_en) begin
            exp_bw = !RESET && (m_refill || !m_hit(PC));
            exp_rd = !RESET && m_refill && !m_arrived;
            check_output("busywait", BUSYWAIT, exp_bw);
            check_output("mem_read", mem_read, exp_rd);
            if (RESET) check_output("mem_address_rst", mem_address, 0);
            else if (exp_rd) check_output("mem_address", mem_address, m_blk);
            if (!exp_bw) begin
                exp_ins = RESET ? 32'd0
                        : mem_word(m_tag[idx_of(PC)] * 8 + idx_of(PC), off_of(PC));
                check_output("instruction", INSTRUCTION, exp_ins);
            end
`ifdef ICACHE_STATS_EN
            check_output("hit_count", hit_count, m_hits);
            check_output("miss_count", miss_count, m_misses);
`endif
        end
    end

    task automatic apply_stimulus(input logic [31:0] pc);
        @(posedge CLK);
        #1 PC = pc;
    endtask

    task automatic wait_ready(output int cycles);
        bit done = 1'b0;
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge CLK);
            #1 cycles++;
            if (!BUSYWAIT) done = 1'b1;
        end
        if (!done) check_output("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1 RESET = 1'b1;
        #1 RESET = 1'b0;
    endtask

    initial begin
        int          n;
        logic [31:0] pc_new;

        RESET = 1'b1;
        PC    = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_output("rst_busywait", BUSYWAIT, 0);
        check_output("rst_instruction", INSTRUCTION, 0);
        check_output("rst_mem_read", mem_read, 0);
        check_output("rst_mem_address", mem_address, 0);

        // Cold miss with a 5-cycle memory
        RESET  = 1'b0;
        chk_en = 1'b1;
        #1 check_output("cold_busywait", BUSYWAIT, 1);
        @(posedge CLK);
        #1 check_output("cold_mem_read", mem_read, 1);
        check_output("cold_mem_address", mem_address, 0);
        wait_ready(n);
        check_output("miss_penalty", n + 1, 7);
        check_output("cold_word0", INSTRUCTION, 32'hC0DE_0000);

        // Spatial hits in the same block
        for (int w = 1; w < 4; w++) begin
            apply_stimulus(32'(w * 4));
            #1 check_output("spatial_busywait", BUSYWAIT, 0);
            check_output("spatial_word", INSTRUCTION, 32'hC0DE_0000 | 32'(w));
            check_output("spatial_mem_read", mem_read, 0);
        end

        // Conflict on index 0
        apply_stimulus(32'h80);
        #1 check_output("conflict_busywait", BUSYWAIT, 1);
        @(posedge CLK);
        #1 check_output("conflict_mem_address", mem_address, 6'h08);
        wait_ready(n);
        check_output("conflict_word", INSTRUCTION, 32'hC0DE_0800);
        apply_stimulus(32'h0);
        #1 check_output("conflict_back_busywait", BUSYWAIT, 1);
        @(posedge CLK);
        #1 check_output("conflict_back_mem_address", mem_address, 6'h00);
        wait_ready(n);
        check_output("conflict_back_word", INSTRUCTION, 32'hC0DE_0000);

        // Reset during cycle 2 of the refill
        apply_stimulus(32'h10);
        @(posedge CLK);
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1 check_output("midrst_mem_read", mem_read, 0);
        check_output("midrst_busywait", BUSYWAIT, 0);
        #1 RESET = 1'b0;
        PC = 32'h0;
        #0.5 check_output("midrst_remiss", BUSYWAIT, 1);
        wait_ready(n);
        check_output("midrst_word", INSTRUCTION, 32'hC0DE_0000);

        // Index spread: eight misses, then eight hits
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) apply_stimulus(32'(i * 16));
            #1 check_output("spread_miss", BUSYWAIT, 1);
            wait_ready(n);
        end
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(32'(i * 16));
            #1 check_output("spread_hit", BUSYWAIT, 0);
            check_output("spread_mem_read", mem_read, 0);
            check_output("spread_word", INSTRUCTION, 32'hC0DE_0000 | (32'(i) << 8));
        end
`ifdef ICACHE_STATS_EN
        check_output("stats_miss8", miss_count, 8);
        check_output("stats_hit8", hit_count, 8);
        apply_stimulus(32'h0);
        repeat (70000) @(posedge CLK);
        #1 check_output("stats_hit_sat", hit_count, 16'hFFFF);
        check_output("stats_miss_hold", miss_count, 8);
`endif

        // Randomized fetch stream with aliasing high bits, varied latency and stray busywait
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK);
            #1;
            noise    = ($urandom_range(0, 3) == 0);
            lat_next = $urandom_range(1, 6);
            if (!(m_refill || !m_hit(PC)) && $urandom_range(0, 3) != 0) begin
                pc_new = $urandom & ~32'h0000_0300;
                PC     = pc_new;
            end
            if ($urandom_range(0, 199) == 0) begin
                #1 RESET = 1'b1;
                #1 RESET = 1'b0;
            end
        end

        @(negedge CLK);
        #1 chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
